// File: rtl/dds_sweep_pkg.sv
// Shared constants and types for the DDS frequency-sweep controller.
package dds_sweep_pkg;

  localparam int unsigned DefaultFreqW  = 32;
  localparam int unsigned DefaultPhaseW = 32;
  localparam int unsigned DefaultDwellW = 16;

  // Sweep modes; 2'b11 is reserved and behaves as a single ramp.
  localparam logic [1:0] MODE_SINGLE = 2'b00;
  localparam logic [1:0] MODE_SAW    = 2'b01;
  localparam logic [1:0] MODE_TRI    = 2'b10;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDwell,
    StFinish
  } sweep_state_e;

  typedef enum logic {
    DirUp,
    DirDown
  } sweep_dir_e;

endpackage

// File: rtl/dds_sweep_next.sv
// Next frequency word: one step up or down, clamped to the sweep endpoints.
module dds_sweep_next
  import dds_sweep_pkg::*;
#(
  parameter int unsigned FREQ_W = DefaultFreqW
) (
  input  logic [FREQ_W-1:0] cur_i,
  input  logic [FREQ_W-1:0] step_i,
  input  logic [FREQ_W-1:0] f_start_i,
  input  logic [FREQ_W-1:0] f_stop_i,
  input  sweep_dir_e        dir_i,
  output logic [FREQ_W-1:0] next_o,
  output logic              hit_stop_o,
  output logic              hit_start_o
);

  logic [FREQ_W:0] sum;
  logic [FREQ_W:0] diff;

  // One extra bit catches carry/borrow so the word never wraps past an endpoint.
  always_comb begin
    sum         = {1'b0, cur_i} + {1'b0, step_i};
    diff        = {1'b0, cur_i} - {1'b0, step_i};
    next_o      = '0;
    hit_stop_o  = 1'b0;
    hit_start_o = 1'b0;
    if (dir_i == DirUp) begin
      if (sum[FREQ_W] || (sum[FREQ_W-1:0] >= f_stop_i)) begin
        next_o     = f_stop_i;
        hit_stop_o = 1'b1;
      end else begin
        next_o = sum[FREQ_W-1:0];
      end
    end else begin
      if (diff[FREQ_W] || (diff[FREQ_W-1:0] <= f_start_i)) begin
        next_o      = f_start_i;
        hit_start_o = 1'b1;
      end else begin
        next_o = diff[FREQ_W-1:0];
      end
    end
  end

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep initiator driving the cordic_dds configuration port.
module dds_sweep_ctrl
  import dds_sweep_pkg::*;
#(
  parameter int unsigned FREQ_W  = DefaultFreqW,
  parameter int unsigned PHASE_W = DefaultPhaseW,
  parameter int unsigned DWELL_W = DefaultDwellW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic [1:0]         mode_i,
  input  logic [FREQ_W-1:0]  f_start_i,
  input  logic [FREQ_W-1:0]  f_stop_i,
  input  logic [FREQ_W-1:0]  f_step_i,
  input  logic [DWELL_W-1:0] dwell_i,
  input  logic [PHASE_W-1:0] phase_i,
  output logic               cfg_vld_o,
  output logic [FREQ_W-1:0]  cfg_freq_word_o,
  output logic [PHASE_W-1:0] cfg_phase_word_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [15:0]        step_cnt_o
);

  sweep_state_e       state_q;
  logic [1:0]         mode_q;
  logic [FREQ_W-1:0]  f_start_q, f_stop_q, f_step_q;
  logic [DWELL_W-1:0] dwell_m1_q, cnt_q;
  logic [PHASE_W-1:0] phase_q;
  sweep_dir_e         dir_q;
  logic               at_stop_q, at_start_q;

  logic               cfg_vld_q, busy_q, done_q;
  logic [FREQ_W-1:0]  cfg_freq_q;
  logic [PHASE_W-1:0] cfg_phase_q;
  logic [15:0]        step_cnt_q;

  logic               degenerate, continuous;
  logic [DWELL_W-1:0] dwell_m1_in;
  sweep_dir_e         step_dir;
  logic [FREQ_W-1:0]  nxt_word;
  logic               nxt_hit_stop, nxt_hit_start;
  logic               finish;
  logic [FREQ_W-1:0]  issue_word;
  logic               issue_stop, issue_start;

  assign degenerate  = (f_step_q == '0) || (f_start_q >= f_stop_q);
  assign continuous  = (mode_q == MODE_SAW) || (mode_q == MODE_TRI);
  assign dwell_m1_in = (dwell_i == '0) ? '0 : dwell_i - DWELL_W'(1);

  // Triangle turns around right after emitting either endpoint; other modes only climb.
  always_comb begin
    step_dir = DirUp;
    if (mode_q == MODE_TRI) begin
      if (at_stop_q) begin
        step_dir = DirDown;
      end else if (at_start_q) begin
        step_dir = DirUp;
      end else begin
        step_dir = dir_q;
      end
    end
  end

  dds_sweep_next #(
    .FREQ_W (FREQ_W)
  ) u_next (
    .cur_i       (cfg_freq_q),
    .step_i      (f_step_q),
    .f_start_i   (f_start_q),
    .f_stop_i    (f_stop_q),
    .dir_i       (step_dir),
    .next_o      (nxt_word),
    .hit_stop_o  (nxt_hit_stop),
    .hit_start_o (nxt_hit_start)
  );

  // End-of-dwell decision: finish the sweep or pick the word for the next pulse.
  always_comb begin
    finish      = 1'b0;
    issue_word  = nxt_word;
    issue_stop  = nxt_hit_stop;
    issue_start = nxt_hit_start;
    if (degenerate) begin
      finish      = !continuous;
      issue_word  = f_start_q;
      issue_stop  = 1'b0;
      issue_start = 1'b1;
    end else if (at_stop_q && !continuous) begin
      finish = 1'b1;
    end else if (at_stop_q && (mode_q == MODE_SAW)) begin
      issue_word  = f_start_q;
      issue_stop  = 1'b0;
      issue_start = 1'b1;
    end
  end

  // Sweep FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      mode_q      <= '0;
      f_start_q   <= '0;
      f_stop_q    <= '0;
      f_step_q    <= '0;
      dwell_m1_q  <= '0;
      cnt_q       <= '0;
      phase_q     <= '0;
      dir_q       <= DirUp;
      at_stop_q   <= 1'b0;
      at_start_q  <= 1'b0;
      cfg_vld_q   <= 1'b0;
      cfg_freq_q  <= '0;
      cfg_phase_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      step_cnt_q  <= '0;
    end else begin
      cfg_vld_q <= 1'b0;
      done_q    <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start_i && !abort_i) begin
            mode_q      <= mode_i;
            f_start_q   <= f_start_i;
            f_stop_q    <= f_stop_i;
            f_step_q    <= f_step_i;
            dwell_m1_q  <= dwell_m1_in;
            phase_q     <= phase_i;
            cnt_q       <= dwell_m1_in;
            dir_q       <= DirUp;
            at_stop_q   <= 1'b0;
            at_start_q  <= 1'b1;
            cfg_vld_q   <= 1'b1;
            cfg_freq_q  <= f_start_i;
            cfg_phase_q <= phase_i;
            busy_q      <= 1'b1;
            step_cnt_q  <= 16'd1;
            state_q     <= StIssue;
          end
        end
        StIssue, StDwell: begin
          if (abort_i) begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else if (cnt_q != '0) begin
            cnt_q   <= cnt_q - DWELL_W'(1);
            state_q <= StDwell;
          end else if (finish) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StFinish;
          end else begin
            cfg_vld_q   <= 1'b1;
            cfg_freq_q  <= issue_word;
            cfg_phase_q <= phase_q;
            at_stop_q   <= issue_stop;
            at_start_q  <= issue_start;
            dir_q       <= step_dir;
            cnt_q       <= dwell_m1_q;
            if (step_cnt_q != 16'hFFFF) begin
              step_cnt_q <= step_cnt_q + 16'd1;
            end
            state_q <= StIssue;
          end
        end
        StFinish: state_q <= StIdle;
        default:  state_q <= StIdle;
      endcase
    end
  end

  assign cfg_vld_o        = cfg_vld_q;
  assign cfg_freq_word_o  = cfg_freq_q;
  assign cfg_phase_word_o = cfg_phase_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign step_cnt_o       = step_cnt_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Scoreboard bench for dds_sweep_ctrl: a word-sequence model feeds expected
// pulses/done events; a negedge monitor compares whatever the DUT emits.
module tb_dds_sweep_ctrl;

  localparam int KZero  = 0;
  localparam int KBusy0 = 1;
  localparam int KFreq  = 2;

  typedef struct {
    int          cyc;
    bit          is_done;
    logic [31:0] word;
    logic [31:0] phase;
    int          cnt;
  } ev_t;

  typedef struct {
    int          cyc;
    int          kind;
    logic [31:0] val;
  } chk_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i, abort_i;
  logic [1:0]  mode_i;
  logic [31:0] f_start_i, f_stop_i, f_step_i, phase_i;
  logic [15:0] dwell_i;
  logic        cfg_vld_o, busy_o, done_o;
  logic [31:0] cfg_freq_word_o, cfg_phase_word_o;
  logic [15:0] step_cnt_o;

  int     cyc = 0;
  int     n_checks = 0;
  int     n_fail = 0;
  bit     mon_en = 1'b0;
  ev_t    exp_q[$];
  chk_t   chk_q[$];
  longint mdl_w[$];
  ev_t    me;
  chk_t   mc;

  dds_sweep_ctrl #(
    .FREQ_W  (32),
    .PHASE_W (32),
    .DWELL_W (16)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .start_i          (start_i),
    .abort_i          (abort_i),
    .mode_i           (mode_i),
    .f_start_i        (f_start_i),
    .f_stop_i         (f_stop_i),
    .f_step_i         (f_step_i),
    .dwell_i          (dwell_i),
    .phase_i          (phase_i),
    .cfg_vld_o        (cfg_vld_o),
    .cfg_freq_word_o  (cfg_freq_word_o),
    .cfg_phase_word_o (cfg_phase_word_o),
    .busy_o           (busy_o),
    .done_o           (done_o),
    .step_cnt_o       (step_cnt_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops expectations whenever the DUT emits a pulse/done or a state check falls due.
  always @(negedge clk) begin
    if (mon_en) begin
      while (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
        me = exp_q.pop_front();
        n_checks++;
        n_fail++;
        $display("FAIL missing_event cyc=%0d: no output seen, required done=%0d word=%h at cycle %0d",
                 cyc, me.is_done, me.word, me.cyc);
      end
      if (cfg_vld_o === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0 || exp_q[0].cyc != cyc || exp_q[0].is_done) begin
          n_fail++;
          $display("FAIL unexpected_pulse cyc=%0d: got word=%h, required no pulse", cyc,
                   cfg_freq_word_o);
        end else begin
          me = exp_q.pop_front();
          if (cfg_freq_word_o !== me.word || cfg_phase_word_o !== me.phase ||
              step_cnt_o !== me.cnt[15:0] || busy_o !== 1'b1 || done_o !== 1'b0) begin
            n_fail++;
            $display("FAIL pulse cyc=%0d: got word=%h phase=%h cnt=%0d busy=%b, required word=%h phase=%h cnt=%0d busy=1",
                     cyc, cfg_freq_word_o, cfg_phase_word_o, step_cnt_o, busy_o, me.word,
                     me.phase, me.cnt);
          end
        end
      end
      if (done_o !== 1'b0) begin
        n_checks++;
        if (exp_q.size() == 0 || exp_q[0].cyc != cyc || !exp_q[0].is_done) begin
          n_fail++;
          $display("FAIL unexpected_done cyc=%0d: got done=%b, required 0", cyc, done_o);
        end else begin
          me = exp_q.pop_front();
          if (busy_o !== 1'b0 || step_cnt_o !== me.cnt[15:0]) begin
            n_fail++;
            $display("FAIL done cyc=%0d: got busy=%b cnt=%0d, required busy=0 cnt=%0d", cyc,
                     busy_o, step_cnt_o, me.cnt);
          end
        end
      end
      while (chk_q.size() != 0 && chk_q[0].cyc <= cyc) begin
        mc = chk_q.pop_front();
        n_checks++;
        if (mc.cyc != cyc) begin
          n_fail++;
          $display("FAIL stale_check kind=%0d: due cycle %0d, reached at %0d", mc.kind, mc.cyc, cyc);
        end else if (mc.kind == KZero) begin
          if ({cfg_vld_o, busy_o, done_o} !== 3'b000 || cfg_freq_word_o !== 32'd0 ||
              cfg_phase_word_o !== 32'd0 || step_cnt_o !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_zero cyc=%0d: got vld=%b busy=%b done=%b word=%h phase=%h cnt=%0d, required all 0",
                     cyc, cfg_vld_o, busy_o, done_o, cfg_freq_word_o, cfg_phase_word_o, step_cnt_o);
          end
        end else if (mc.kind == KBusy0) begin
          if (busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_low cyc=%0d: got busy=%b, required 0", cyc, busy_o);
          end
        end else begin
          if (cfg_freq_word_o !== mc.val) begin
            n_fail++;
            $display("FAIL freq_hold cyc=%0d: got word=%h, required %h", cyc, cfg_freq_word_o,
                     mc.val);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_chk(input int c, input int kind, input logic [31:0] val);
    chk_t x;
    x.cyc  = c;
    x.kind = kind;
    x.val  = val;
    chk_q.push_back(x);
  endtask

  // Reference sequence of emitted words, straight from the sweep rules (64-bit, no wrap).
  task automatic model_words(input logic [1:0] mode, input longint fs, input longint fe,
                             input longint st, input int nmax);
    longint cur;
    bit     up;
    bit     cont;
    mdl_w.delete();
    cont = (mode == 2'b01) || (mode == 2'b10);
    if (st == 0 || fs >= fe) begin
      if (!cont) mdl_w.push_back(fs);
      else repeat (nmax) mdl_w.push_back(fs);
      return;
    end
    cur = fs;
    up  = 1'b1;
    while (mdl_w.size() < nmax) begin
      mdl_w.push_back(cur);
      if (up) begin
        if (cur == fe) begin
          if (!cont) return;
          if (mode == 2'b01) begin
            cur = fs;
            continue;
          end
          up = 1'b0;
        end
      end else if (cur == fs) begin
        up = 1'b1;
      end
      if (up) cur = (cur + st >= fe) ? fe : cur + st;
      else    cur = (cur - st <= fs) ? fs : cur - st;
    end
  endtask

  // Run one sweep: queue the model's expectations, then drive start (and abort for continuous).
  task automatic do_sweep(input logic [1:0] mode, input logic [31:0] fs, input logic [31:0] fe,
                          input logic [31:0] st, input logic [15:0] dw, input logic [31:0] ph,
                          input int abort_after, input int tail, input int restart_off,
                          input bit scramble);
    int          d, t0, a, end_c, n;
    bit          cont;
    ev_t         e;
    logic [31:0] last_w;
    longint      lfs, lfe, lst;
    d    = (dw == 16'd0) ? 1 : int'(dw);
    cont = (mode == 2'b01) || (mode == 2'b10);
    t0   = cyc;
    a    = t0 + abort_after;
    lfs  = longint'(fs);
    lfe  = longint'(fe);
    lst  = longint'(st);
    model_words(mode, lfs, lfe, lst, cont ? (abort_after / d + 2) : 100000);
    last_w = 32'd0;
    n      = 0;
    for (int k = 0; k < mdl_w.size(); k++) begin
      if (cont && (t0 + 1 + k * d > a)) break;
      e.cyc     = t0 + 1 + k * d;
      e.is_done = 1'b0;
      e.word    = 32'(mdl_w[k]);
      e.phase   = ph;
      e.cnt     = (k + 1 > 65535) ? 65535 : k + 1;
      exp_q.push_back(e);
      last_w = e.word;
      n++;
    end
    if (!cont) begin
      e.cyc     = t0 + 1 + n * d;
      e.is_done = 1'b1;
      e.cnt     = n;
      exp_q.push_back(e);
      end_c = e.cyc;
    end else begin
      end_c = a + 1;
      push_chk(end_c, KBusy0, 32'd0);
      push_chk(end_c, KFreq, last_w);
    end
    if (tail > 0) begin
      push_chk(end_c + tail, KBusy0, 32'd0);
      push_chk(end_c + tail, KFreq, last_w);
    end
    mode_i    = mode;
    f_start_i = fs;
    f_stop_i  = fe;
    f_step_i  = st;
    dwell_i   = dw;
    phase_i   = ph;
    start_i   = 1'b1;
    step();
    start_i = 1'b0;
    if (scramble) begin
      mode_i    = 2'($urandom);
      f_start_i = $urandom;
      f_stop_i  = $urandom;
      f_step_i  = $urandom;
      dwell_i   = 16'($urandom);
      phase_i   = $urandom;
    end
    while (cyc <= end_c + tail) begin
      abort_i = cont && (cyc == a);
      start_i = (restart_off > 0) && (cyc == t0 + restart_off);
      step();
    end
    abort_i = 1'b0;
    start_i = 1'b0;
  endtask

  initial begin
    int          t0;
    ev_t         e;
    logic [31:0] fs, fe, st;
    rst       = 1'b1;
    start_i   = 1'b0;
    abort_i   = 1'b0;
    mode_i    = 2'b00;
    f_start_i = 32'd0;
    f_stop_i  = 32'd0;
    f_step_i  = 32'd0;
    dwell_i   = 16'd0;
    phase_i   = 32'd0;
    repeat (3) step();
    push_chk(cyc, KZero, 32'd0);
    mon_en = 1'b1;
    rst    = 1'b0;
    step();

    // Directed ramps, triangle, sawtooth abort on the third dwell cycle, corners.
    do_sweep(2'b00, 32'd100, 32'd400, 32'd100, 16'd4, 32'h1234_5678, 0, 3, 0, 1'b0);
    do_sweep(2'b00, 32'hFFFF_FF00, 32'hFFFF_FFFF, 32'h0000_0200, 16'd1, 32'hA5A5_0001, 0, 2, 0,
             1'b1);
    do_sweep(2'b10, 32'd10, 32'd30, 32'd10, 16'd2, 32'h0000_0042, 20, 0, 0, 1'b0);
    do_sweep(2'b01, 32'd1000, 32'd5000, 32'd700, 16'd5, 32'hDEAD_BEEF, 3, 100, 0, 1'b0);
    do_sweep(2'b00, 32'd77, 32'd900, 32'd0, 16'd0, 32'h0BAD_F00D, 0, 2, 0, 1'b0);
    do_sweep(2'b11, 32'd50, 32'd80, 32'd20, 16'd3, 32'h0000_0003, 0, 1, 0, 1'b0);
    do_sweep(2'b00, 32'd100, 32'd400, 32'd100, 16'd4, 32'h5555_AAAA, 0, 1, 6, 1'b1);

    // Start together with abort in IDLE: nothing may happen.
    push_chk(cyc + 1, KBusy0, 32'd0);
    push_chk(cyc + 15, KBusy0, 32'd0);
    mode_i    = 2'b01;
    f_start_i = 32'd5;
    f_stop_i  = 32'd50;
    f_step_i  = 32'd5;
    dwell_i   = 16'd1;
    start_i   = 1'b1;
    abort_i   = 1'b1;
    step();
    start_i = 1'b0;
    abort_i = 1'b0;
    repeat (20) step();

    // Reset during a dwell, then a fresh sweep.
    t0        = cyc;
    e.cyc     = t0 + 1;
    e.is_done = 1'b0;
    e.word    = 32'd500;
    e.phase   = 32'h0000_0777;
    e.cnt     = 1;
    exp_q.push_back(e);
    push_chk(t0 + 4, KZero, 32'd0);
    mode_i    = 2'b01;
    f_start_i = 32'd500;
    f_stop_i  = 32'd900;
    f_step_i  = 32'd100;
    dwell_i   = 16'd6;
    phase_i   = 32'h0000_0777;
    start_i   = 1'b1;
    step();
    start_i = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (2) step();
    do_sweep(2'b00, 32'd20, 32'd60, 32'd15, 16'd2, 32'h0000_0999, 0, 1, 0, 1'b0);

    // Randomised sweeps across all modes, including near-overflow and near-zero ranges.
    for (int i = 0; i < 30; i++) begin
      int r;
      r = $urandom_range(0, 3);
      if (r == 0) begin
        fs = 32'hFFFF_FFFF - $urandom_range(0, 3000);
        fe = fs + $urandom_range(0, 32'hFFFF_FFFF - fs);
      end else if (r == 1) begin
        fs = $urandom_range(0, 20);
        fe = fs + $urandom_range(0, 3000);
      end else begin
        fs = $urandom_range(0, 10000);
        fe = ($urandom_range(0, 7) == 0) ? fs - $urandom_range(0, 50)
                                         : fs + $urandom_range(0, 3000);
      end
      if ($urandom_range(0, 7) == 0 || fe <= fs) st = 32'($urandom_range(0, 1)) * 32'd9;
      else st = $urandom_range((fe - fs) / 16 + 1, (fe - fs) + 100);
      do_sweep(2'($urandom), fs, fe, st, 16'($urandom_range(0, 4)), $urandom,
               $urandom_range(1, 60), $urandom_range(0, 3), 0, 1'($urandom));
    end

    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
